// File: rtl/synth_pkg.sv
// Shared definitions for the audio synth datapath: sample width, PWM timebase
// and the sample scheduler state encoding.
package synth_pkg;
  localparam int         SAMPLE_W   = 8;
  localparam int         PWM_PERIOD = 256;
  localparam logic [7:0] MIDSCALE   = 8'd128;

  typedef enum logic [1:0] {IDLE, SCAN, MIX, HOLD} sched_state_t;
endpackage

// File: rtl/pwm_frame_timer.sv
// PWM period counter with frame-start and wrap decode; shared with the PWM
// stage so scheduler and PWM compare run from one timebase.
module pwm_frame_timer #(
  parameter int PERIOD = synth_pkg::PWM_PERIOD,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic clk,
  input  logic nRst,
  output logic o_frame_start,
  output logic o_wrap
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)       r_count <= '0;
    else if (o_wrap) r_count <= '0;
    else             r_count <= r_count + 1'b1;
  end

  assign o_frame_start = (r_count == '0);
  assign o_wrap        = (r_count == CNT_W'(PERIOD - 1));
endmodule

// File: rtl/pwm_sample_scheduler.sv
// Polls each voice once per PWM period, averages the collected samples and
// updates mixed_sample only on the period wrap.
module pwm_sample_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = synth_pkg::SAMPLE_W,
  parameter int PERIOD     = synth_pkg::PWM_PERIOD
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic                           en,
  input  logic [NUM_VOICES-1:0]          voice_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES-1:0]          voice_ready,
  output logic [SAMPLE_W-1:0]            mixed_sample,
  output logic                           frame_start,
  output logic [NUM_VOICES-1:0]          underrun
);
  import synth_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  sched_state_t          r_state, w_nstate;
  logic [IDX_W-1:0]      r_idx, w_nidx;
  logic [ACC_W-1:0]      r_acc;
  logic [SAMPLE_W-1:0]   r_pending, r_mixed, w_sample;
  logic [NUM_VOICES-1:0] r_underrun;
  logic                  w_frame_start, w_wrap, w_start, w_take;

  pwm_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk           (clk),
    .nRst          (nRst),
    .o_frame_start (w_frame_start),
    .o_wrap        (w_wrap)
  );

  // Sampled in the counter==0 cycle, so SCAN(k) lands on count k+1.
  assign w_start = (r_state == IDLE || r_state == HOLD) && w_frame_start && en;
  assign w_take  = (r_state == SCAN) && voice_valid[r_idx];

  always_comb begin
    w_sample = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (r_idx == IDX_W'(i)) w_sample = voice_sample[i*SAMPLE_W +: SAMPLE_W];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    case (r_state)
      IDLE, HOLD: begin
        if (w_start) begin
          w_nstate = SCAN;
          w_nidx   = '0;
        end else if (r_state == HOLD && w_frame_start) begin
          w_nstate = IDLE;
        end
      end
      SCAN: begin
        w_nidx = r_idx + 1'b1;
        if (r_idx == IDX_W'(NUM_VOICES - 1)) w_nstate = MIX;
      end
      MIX:     w_nstate = HOLD;
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    voice_ready = '0;
    if (w_take) voice_ready[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_acc      <= '0;
      r_pending  <= '0;
      r_mixed    <= '0;
      r_underrun <= '0;
    end else begin
      if (w_start)     r_acc <= '0;
      else if (w_take) r_acc <= r_acc + ACC_W'(w_sample);

      // Fixed divide by NUM_VOICES; missing voices count as zero.
      if (r_state == MIX)                r_pending <= SAMPLE_W'(r_acc >> IDX_W);
      else if (w_wrap && r_state == IDLE) r_pending <= MID;

      if (w_wrap) r_mixed <= (r_state == IDLE) ? MID : r_pending;

      if (r_state == SCAN && !voice_valid[r_idx]) r_underrun[r_idx] <= 1'b1;
      else if (r_state == IDLE && !en)            r_underrun <= '0;
    end
  end

  assign frame_start  = w_frame_start;
  assign mixed_sample = r_mixed;
  assign underrun     = r_underrun;
endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Frame-level bench: table of per-frame voice inputs with expected mix and
// underrun, scoreboarded one frame later, plus enable-drop and reset sequences.
module tb_pwm_sample_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0, nRst = 1'b0, en = 1'b0;
  logic [N-1:0]   voice_valid = '0;
  logic [N*W-1:0] voice_sample = '0;
  logic [N-1:0]   voice_ready, underrun;
  logic [W-1:0]   mixed_sample;
  logic           frame_start;

  int checks = 0, errors = 0;
  int m_cnt;

  always #5 clk = ~clk;

  pwm_sample_scheduler #(.NUM_VOICES(N), .SAMPLE_W(W), .PERIOD(256)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .en           (en),
    .voice_valid  (voice_valid),
    .voice_sample (voice_sample),
    .voice_ready  (voice_ready),
    .mixed_sample (mixed_sample),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  // reference period counter
  always @(posedge clk or negedge nRst)
    if (!nRst) m_cnt <= 0;
    else       m_cnt <= (m_cnt == 255) ? 0 : m_cnt + 1;

  typedef struct {
    logic [N*W-1:0] smp;
    logic [N-1:0]   vld;
    bit             late0;
    logic [W-1:0]   mix;
    logic [N-1:0]   und;
  } vec_t;

  typedef struct {
    logic [W-1:0] mix;
    logic [N-1:0] und;
  } exp_t;

  vec_t tv[10];
  exp_t q[$];

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic goto_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 600);
    if (m_cnt != c) begin
      checks++;
      errors++;
      $display("FAIL goto_cnt: counter %0d expected %0d", m_cnt, c);
    end
  endtask

  initial begin
    exp_t         e;
    logic [N-1:0] er;
    logic [W-1:0] cur;

    tv[0] = '{pk(10, 20, 30, 40),     4'b1111, 1'b0, 8'd25,  4'b0000};
    tv[1] = '{pk(10, 20, 99, 40),     4'b1011, 1'b0, 8'd17,  4'b0100};
    tv[2] = '{pk(255, 255, 255, 255), 4'b1111, 1'b0, 8'd255, 4'b0100};
    tv[3] = '{pk(0, 0, 0, 0),         4'b1111, 1'b0, 8'd0,   4'b0100};
    tv[4] = '{pk(255, 255, 255, 254), 4'b1111, 1'b0, 8'd254, 4'b0100};
    tv[5] = '{pk(7, 0, 0, 0),         4'b1111, 1'b0, 8'd1,   4'b0100};
    tv[6] = '{pk(10, 20, 30, 40),     4'b1110, 1'b1, 8'd22,  4'b0101};
    tv[7] = '{pk(10, 20, 30, 40),     4'b1111, 1'b0, 8'd25,  4'b0101};
    tv[8] = '{pk(50, 50, 50, 50),     4'b0000, 1'b0, 8'd0,   4'b1111};
    tv[9] = '{pk(10, 20, 30, 40),     4'b1111, 1'b0, 8'd25,  4'b1111};

    en = 1'b1;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    #1;
    chk("rst_mixed", mixed_sample, 0);
    chk("rst_ready", voice_ready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_frame_start", frame_start, 1);
    cur = '0;

    for (int i = 0; i < 10; i++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mixed", mixed_sample, e.mix);
        chk("underrun", underrun, e.und);
        cur = e.mix;
      end
      chk("frame_start", frame_start, 1);
      voice_sample = tv[i].smp;
      voice_valid  = tv[i].vld;
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        er = '0;
        if (tv[i].vld[k]) er[k] = 1'b1;
        chk("ready_slot", voice_ready, er);
      end
      if (tv[i].late0) begin
        goto_cnt(5);
        voice_valid[0] = 1'b1;
        @(negedge clk);
        chk("late_ready", voice_ready, 0);
      end
      q.push_back('{mix: tv[i].mix, und: tv[i].und});
      goto_cnt(128);
      chk("hold_mixed", mixed_sample, cur);
      chk("mid_frame_start", frame_start, 0);
      goto_cnt(0);
    end

    // en dropped mid-frame: current frame still lands, then midscale
    e = q.pop_front();
    chk("mixed", mixed_sample, e.mix);
    chk("underrun", underrun, e.und);
    goto_cnt(100);
    en = 1'b0;
    goto_cnt(0);
    chk("drain_mixed", mixed_sample, 25);
    chk("drain_underrun", underrun, 4'b1111);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("idle_ready", voice_ready, 0);
    end
    goto_cnt(10);
    chk("idle_underrun_clr", underrun, 0);
    goto_cnt(128);
    chk("idle_hold_mixed", mixed_sample, 25);
    goto_cnt(0);
    chk("midscale", mixed_sample, 128);

    // reset during SCAN(2)
    en = 1'b1;
    voice_sample = pk(200, 200, 200, 200);
    voice_valid  = 4'b1110;
    repeat (3) @(negedge clk);
    chk("scan2_ready", voice_ready, 4'b0100);
    chk("scan2_underrun", underrun, 4'b0001);
    nRst = 1'b0;
    #1;
    chk("abort_mixed", mixed_sample, 0);
    chk("abort_ready", voice_ready, 0);
    chk("abort_underrun", underrun, 0);
    chk("abort_frame_start", frame_start, 1);
    q.delete();
    repeat (2) @(negedge clk);
    voice_sample = pk(10, 20, 30, 40);
    voice_valid  = 4'b1111;
    nRst = 1'b1;
    goto_cnt(255);
    chk("post_rst_pre_wrap", mixed_sample, 0);
    goto_cnt(0);
    chk("post_rst_mixed", mixed_sample, 25);
    chk("post_rst_underrun", underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
